fetch_prefetch_queue: RTL and testbench

- Fetch-stage prefetch queue. It sits directly downstream of the EIP register and upstream of decode.
- It requests 16-byte aligned lines from the I-cache and holds two lines.
- It presents decode with a 16-byte instruction window that starts at the current instruction byte.
- A writeback redirect (branch or EIP change) flushes the queue and restarts fetch at the target.

---
 rtl/fpq_pkg.sv | 13 +
 rtl/fpq_checker.sv | 11 +
 rtl/fpq_window_align.sv | 25 ++
 rtl/mux_nbit_2x1.sv | 11 +
 rtl/fetch_prefetch_queue.sv | 135 +++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 180 ++++++++++++++++++
 6 files changed

// File: rtl/fpq_pkg.sv
// Shared types and constants for the fetch-stage prefetch queue.
package fpq_pkg;
  localparam int LINE_BYTES = 16;
  localparam int PTR_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    SQUASH = 2'd2
  } fpq_state_e;

  typedef logic [27:0] line_idx_t;
endpackage

// File: rtl/fpq_checker.sv
// Protocol checks on the decode-consume interface.
module fpq_checker (
  input logic       clk,
  input logic       rst_n,
  input logic       consume,
  input logic [4:0] len
);
  // An accepted consume must retire between 1 and 16 bytes.
  a_len_legal : assert property (@(posedge clk) disable iff (!rst_n)
    consume |-> (len != 5'd0 && len <= 5'd16));
endmodule

// File: rtl/fpq_window_align.sv
// Byte rotator: selects 16 bytes starting at byte ptr of a 32-byte line pair.
module fpq_window_align
  import fpq_pkg::*;
(
  input  logic [2*LINE_BYTES*8-1:0] lines,
  input  logic [PTR_W-1:0]          ptr,
  output logic [LINE_BYTES*8-1:0]   window
);
  logic [2*LINE_BYTES*8-1:0] stage_s [0:PTR_W];

  assign stage_s[0] = lines;

  // Log shifter: stage k moves the pair down by 2^k bytes when ptr[k] is set.
  for (genvar k = 0; k < PTR_W; k++) begin : g_stage
    localparam int SH = 8 << k;
    mux_nbit_2x1 #(.N(2*LINE_BYTES*8)) u_mux (
      .a   (stage_s[k]),
      .b   (stage_s[k] >> SH),
      .sel (ptr[k]),
      .y   (stage_s[k+1])
    );
  end

  assign window = stage_s[PTR_W][LINE_BYTES*8-1:0];
endmodule

// File: rtl/mux_nbit_2x1.sv
// Generic N-bit two-input multiplexer.
module mux_nbit_2x1 #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sel,
  output logic [N-1:0] y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/fetch_prefetch_queue.sv
// Two-line prefetch queue between the EIP register and decode; presents a
// 16-byte window at the current EIP and restarts on writeback redirect.
module fetch_prefetch_queue
  import fpq_pkg::*;
#(
  parameter logic [31:0] RESET_EIP = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_redirect,
  input  logic [31:0]  i_redirect_eip,
  output logic         o_ic_req,
  output logic [27:0]  o_ic_addr,
  input  logic         i_ic_ack,
  input  logic [127:0] i_ic_data,
  output logic         o_de_valid,
  output logic [127:0] o_de_window,
  output logic [31:0]  o_de_eip,
  input  logic         i_de_consume,
  input  logic [4:0]   i_de_len
);
  fpq_state_e       state_r, state_s;
  logic [127:0]     line0_r, line1_r, line0_s, line1_s;
  logic             v0_r, v1_r, v0_s, v1_s;
  line_idx_t        base_r, base_s, fetch_addr_r, fetch_addr_s;
  line_idx_t        squash_addr_r, squash_addr_s;
  logic [PTR_W-1:0] ptr_r, ptr_s;

  logic             de_valid_s, consume_s, shift_s, fill_s;
  logic [4:0]       sum_s;

  assign de_valid_s = v0_r && ((ptr_r == 4'd0) || v1_r);
  assign consume_s  = i_de_consume && de_valid_s;
  assign sum_s      = {1'b0, ptr_r} + i_de_len;
  assign shift_s    = consume_s && sum_s[4];
  assign fill_s     = (state_r == REQ) && i_ic_ack;

  // Next-state: consume shift, then fill, then FSM; redirect overrides all.
  always_comb begin
    state_s       = state_r;
    line0_s       = shift_s ? line1_r : line0_r;
    line1_s       = line1_r;
    v0_s          = shift_s ? v1_r : v0_r;
    v1_s          = shift_s ? 1'b0 : v1_r;
    base_s        = shift_s ? base_r + 28'd1 : base_r;
    ptr_s         = consume_s ? sum_s[3:0] : ptr_r;
    fetch_addr_s  = fetch_addr_r;
    squash_addr_s = squash_addr_r;

    if (fill_s) begin
      fetch_addr_s = fetch_addr_r + 28'd1;
      if (!v0_s) begin
        line0_s = i_ic_data;
        v0_s    = 1'b1;
      end else begin
        line1_s = i_ic_data;
        v1_s    = 1'b1;
      end
    end else begin
      fetch_addr_s = fetch_addr_r;
    end

    case (state_r)
      IDLE:    state_s = (v0_s && v1_s) ? IDLE : REQ;
      REQ:     state_s = (i_ic_ack && v0_s && v1_s) ? IDLE : REQ;
      SQUASH:  state_s = i_ic_ack ? REQ : SQUASH;
      default: state_s = REQ;
    endcase

    if (i_redirect) begin
      v0_s         = 1'b0;
      v1_s         = 1'b0;
      base_s       = i_redirect_eip[31:4];
      ptr_s        = i_redirect_eip[3:0];
      fetch_addr_s = i_redirect_eip[31:4];
      // An unacked request must still be completed at its original address.
      if ((state_r == REQ || state_r == SQUASH) && !i_ic_ack) begin
        state_s = SQUASH;
        if (state_r == REQ) begin
          squash_addr_s = fetch_addr_r;
        end else begin
          squash_addr_s = squash_addr_r;
        end
      end else begin
        state_s = REQ;
      end
    end else begin
      squash_addr_s = squash_addr_s;
    end
  end

  // Queue state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= REQ;
      line0_r       <= 128'd0;
      line1_r       <= 128'd0;
      v0_r          <= 1'b0;
      v1_r          <= 1'b0;
      base_r        <= RESET_EIP[31:4];
      ptr_r         <= RESET_EIP[3:0];
      fetch_addr_r  <= RESET_EIP[31:4];
      squash_addr_r <= RESET_EIP[31:4];
    end else begin
      state_r       <= state_s;
      line0_r       <= line0_s;
      line1_r       <= line1_s;
      v0_r          <= v0_s;
      v1_r          <= v1_s;
      base_r        <= base_s;
      ptr_r         <= ptr_s;
      fetch_addr_r  <= fetch_addr_s;
      squash_addr_r <= squash_addr_s;
    end
  end

  // Reset gates the request directly so it drops without waiting for a clock.
  assign o_ic_req   = rst_n && (state_r != IDLE);
  assign o_ic_addr  = (state_r == SQUASH) ? squash_addr_r : fetch_addr_r;
  assign o_de_valid = de_valid_s;
  assign o_de_eip   = {base_r, ptr_r};

  fpq_window_align u_align (
    .lines  ({line1_r, line0_r}),
    .ptr    (ptr_r),
    .window (o_de_window)
  );

  fpq_checker u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .consume (consume_s),
    .len     (i_de_len)
  );
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed self-checking bench for fetch_prefetch_queue.
module tb_fetch_prefetch_queue;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_redirect;
  logic [31:0]  i_redirect_eip;
  logic         o_ic_req;
  logic [27:0]  o_ic_addr;
  logic         i_ic_ack;
  logic [127:0] i_ic_data;
  logic         o_de_valid;
  logic [127:0] o_de_window;
  logic [31:0]  o_de_eip;
  logic         i_de_consume;
  logic [4:0]   i_de_len;

  int compared = 0;
  int mismatched = 0;
  logic [127:0] w_exp;
  logic [7:0]   b_exp;

  always #5 clk = ~clk;

  fetch_prefetch_queue #(.RESET_EIP(32'h0000_0100)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_redirect     (i_redirect),
    .i_redirect_eip (i_redirect_eip),
    .o_ic_req       (o_ic_req),
    .o_ic_addr      (o_ic_addr),
    .i_ic_ack       (i_ic_ack),
    .i_ic_data      (i_ic_data),
    .o_de_valid     (o_de_valid),
    .o_de_window    (o_de_window),
    .o_de_eip       (o_de_eip),
    .i_de_consume   (i_de_consume),
    .i_de_len       (i_de_len)
  );

  function automatic logic [127:0] line_of(input logic [27:0] a);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] n;
      n = 4'(i);
      r[i*8 +: 8] = a[7:0] ^ a[15:8] ^ {n, n};
    end
    return r;
  endfunction

  function automatic logic [127:0] win(input logic [127:0] l0, input logic [127:0] l1,
                                       input int p);
    logic [255:0] cat;
    logic [127:0] r;
    cat = {l1, l0};
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = cat[(p+i)*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; i_redirect = 1'b0; i_redirect_eip = 32'd0;
    i_ic_ack = 1'b0; i_ic_data = 128'd0; i_de_consume = 1'b0; i_de_len = 5'd1;
    cyc(); cyc();
    chk("rst_req", 128'(o_ic_req), 128'd0);
    chk("rst_valid", 128'(o_de_valid), 128'd0);
    chk("rst_eip", 128'(o_de_eip), 128'h100);
    chk("rst_window", o_de_window, 128'd0);

    // 1: first two line fetches
    rst_n = 1'b1; #1;
    chk("t1_req", 128'(o_ic_req), 128'd1);
    chk("t1_addr0", 128'(o_ic_addr), 128'h10);
    cyc();
    chk("t1_addr_hold", 128'(o_ic_addr), 128'h10);
    i_ic_ack = 1'b1; i_ic_data = line_of(28'h10); cyc(); i_ic_ack = 1'b0;
    chk("t1_valid", 128'(o_de_valid), 128'd1);
    chk("t1_eip", 128'(o_de_eip), 128'h100);
    chk("t1_window", o_de_window, line_of(28'h10));
    chk("t1_addr1", 128'(o_ic_addr), 128'h11);
    i_ic_ack = 1'b1; i_ic_data = line_of(28'h11); cyc(); i_ic_ack = 1'b0;
    chk("t1_idle_req", 128'(o_ic_req), 128'd0);

    // 2: four consumes of 5 bytes
    i_de_consume = 1'b1; i_de_len = 5'd5;
    cyc();
    chk("t2_eip5", 128'(o_de_eip), 128'h105);
    w_exp = win(line_of(28'h10), line_of(28'h11), 5);
    chk("t2_win5", o_de_window, w_exp);
    cyc();
    chk("t2_eipA", 128'(o_de_eip), 128'h10A);
    cyc();
    chk("t2_eipF", 128'(o_de_eip), 128'h10F);
    w_exp = win(line_of(28'h10), line_of(28'h11), 15);
    chk("t2_winF", o_de_window, w_exp);
    cyc();
    i_de_consume = 1'b0;
    chk("t2_eip114", 128'(o_de_eip), 128'h114);
    chk("t2_valid", 128'(o_de_valid), 128'd0);
    chk("t2_req", 128'(o_ic_req), 128'd1);
    chk("t2_addr", 128'(o_ic_addr), 128'h12);

    // 3: redirect while request to 0x12 is outstanding
    i_redirect = 1'b1; i_redirect_eip = 32'h0000_2007; cyc(); i_redirect = 1'b0;
    chk("t3_eip", 128'(o_de_eip), 128'h2007);
    chk("t3_valid0", 128'(o_de_valid), 128'd0);
    chk("t3_sq_req", 128'(o_ic_req), 128'd1);
    chk("t3_sq_addr", 128'(o_ic_addr), 128'h12);
    i_ic_ack = 1'b1; i_ic_data = line_of(28'h12); cyc(); i_ic_ack = 1'b0;
    chk("t3_addr200", 128'(o_ic_addr), 128'h200);
    chk("t3_valid1", 128'(o_de_valid), 128'd0);
    i_ic_ack = 1'b1; i_ic_data = line_of(28'h200); cyc(); i_ic_ack = 1'b0;
    chk("t3_valid2", 128'(o_de_valid), 128'd0);
    chk("t3_addr201", 128'(o_ic_addr), 128'h201);
    i_ic_ack = 1'b1; i_ic_data = line_of(28'h201); cyc(); i_ic_ack = 1'b0;
    chk("t3_valid3", 128'(o_de_valid), 128'd1);
    chk("t3_eip2007", 128'(o_de_eip), 128'h2007);
    w_exp = win(line_of(28'h200), line_of(28'h201), 7);
    chk("t3_window", o_de_window, w_exp);
    w_exp = line_of(28'h200);
    b_exp = w_exp[63:56];
    chk("t3_byte0", 128'(o_de_window[7:0]), 128'(b_exp));

    // 4: shift and fill in the same cycle
    i_de_consume = 1'b1; i_de_len = 5'd9; cyc(); i_de_consume = 1'b0;
    chk("t4_eip", 128'(o_de_eip), 128'h2010);
    chk("t4_valid", 128'(o_de_valid), 128'd1);
    chk("t4_window", o_de_window, line_of(28'h201));
    chk("t4_addr", 128'(o_ic_addr), 128'h202);
    i_de_consume = 1'b1; i_de_len = 5'd16;
    i_ic_ack = 1'b1; i_ic_data = line_of(28'h202); cyc();
    i_de_consume = 1'b0; i_ic_ack = 1'b0;
    chk("t4b_valid", 128'(o_de_valid), 128'd1);
    chk("t4b_eip", 128'(o_de_eip), 128'h2020);
    chk("t4b_window", o_de_window, line_of(28'h202));
    chk("t4b_addr", 128'(o_ic_addr), 128'h203);
    i_ic_ack = 1'b1; i_ic_data = line_of(28'h203); cyc(); i_ic_ack = 1'b0;
    chk("t4c_req", 128'(o_ic_req), 128'd0);
    chk("t4c_window", o_de_window, line_of(28'h202));

    // 5: fetch address wrap
    i_redirect = 1'b1; i_redirect_eip = 32'hFFFF_FFF0; cyc(); i_redirect = 1'b0;
    chk("t5_addr", 128'(o_ic_addr), 128'hFFF_FFFF);
    chk("t5_eip", 128'(o_de_eip), 128'hFFFF_FFF0);
    i_ic_ack = 1'b1; i_ic_data = line_of(28'hFFF_FFFF); cyc(); i_ic_ack = 1'b0;
    chk("t5_wrap", 128'(o_ic_addr), 128'h0);
    chk("t5_valid", 128'(o_de_valid), 128'd1);
    i_ic_ack = 1'b1; i_ic_data = line_of(28'h0); cyc(); i_ic_ack = 1'b0;
    i_de_consume = 1'b1; i_de_len = 5'd16; cyc(); i_de_consume = 1'b0;
    chk("t5_eip_wrap", 128'(o_de_eip), 128'h0);
    chk("t5_window", o_de_window, line_of(28'h0));
    chk("t5_addr1", 128'(o_ic_addr), 128'h1);

    // 6: reset during an outstanding request
    rst_n = 1'b0; #1;
    chk("t6_req", 128'(o_ic_req), 128'd0);
    chk("t6_valid", 128'(o_de_valid), 128'd0);
    chk("t6_eip", 128'(o_de_eip), 128'h100);
    cyc();
    rst_n = 1'b1; #1;
    chk("t6_req_rel", 128'(o_ic_req), 128'd1);
    chk("t6_addr_rel", 128'(o_ic_addr), 128'h10);
    i_ic_ack = 1'b1; i_ic_data = line_of(28'h10); cyc(); i_ic_ack = 1'b0;
    chk("t6_window", o_de_window, line_of(28'h10));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
